dbus_wb_master: RTL and testbench
=================================

DBUS_WB_MASTER -- requirements
Module: dbus_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: number of BUS-state cycles without ack/err before a timeout error.
REQ-002 SHALL have clk_i  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have req_valid_i  input  1  memory request from LSU (is_mem and no misalignment exception).
REQ-005 SHALL have req_ready_o  output  1  block can accept a request this cycle.
REQ-006 SHALL have we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have addr_i  input  32  byte address.
REQ-008 SHALL have st_data_i  input  32  formatted store data (lane-replicated).
REQ-009 SHALL have st_sel_i  input  4  store byte enables.
REQ-010 SHALL have ld_data_o  output  32  raw load word, fed to the load formatter.
REQ-011 SHALL have done_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have err_o  output  1  one-cycle bus-error pulse, coincident with done_o.
REQ-013 SHALL have wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic cycle, strobe and write.
REQ-014 SHALL have wbm_adr_o  output  32  and wbm_dat_o  output  32  and wbm_sel_o  output  4.
REQ-015 SHALL have wbm_dat_i  input  32  and wbm_ack_i, wbm_err_i  input  1 each.

Function
REQ-016 SHALL implement FSM states IDLE, BUS, RESP.
REQ-017 SHALL assert req_ready_o only in IDLE.
REQ-018 IDLE, req_valid_i=1: SHALL register we_i, addr_i, st_data_i, st_sel_i and enter BUS; otherwise SHALL stay in IDLE.
REQ-019 SHALL ignore inputs other than req_valid_i and the request fields while not in IDLE.
REQ-020 SHALL drive wbm_cyc_o=wbm_stb_o=1 throughout BUS and 0 in IDLE and RESP.
REQ-021 SHALL drive wbm_adr_o = {addr[31:2],2'b00} from the registered address.
REQ-022 SHALL drive wbm_we_o to the registered we.
REQ-023 Store: SHALL drive wbm_sel_o to the registered st_sel and wbm_dat_o to the registered st_data.
REQ-024 Load: SHALL drive wbm_sel_o=4'b1111 and wbm_dat_o=0.
REQ-025 Wishbone outputs SHALL stay stable for the entire BUS state.
REQ-026 BUS, wbm_ack_i=1, load: SHALL capture wbm_dat_i into ld_data_o and enter RESP.
REQ-027 BUS, wbm_ack_i=1, store: SHALL enter RESP with ld_data_o unchanged.
REQ-028 BUS, wbm_err_i=1: SHALL set the error flag, enter RESP and leave ld_data_o unchanged.
REQ-029 wbm_ack_i and wbm_err_i high together: err SHALL take priority.
REQ-030 SHALL keep a cycle counter cleared on BUS entry and incremented each BUS cycle without ack/err.
REQ-031 Counter reaching TIMEOUT: SHALL treat it as wbm_err_i, drop cyc/stb and enter RESP.
REQ-032 RESP: SHALL assert done_o=1 and err_o=error flag for exactly one cycle, then return to IDLE and clear the error flag.
REQ-033 Latency: request accepted in cycle N gives cyc/stb high from N+1; ack/err in cycle M (M>=N+1) gives done_o in M+1; req_ready_o returns high in M+2.
REQ-034 ld_data_o SHALL hold its value until the next successful load completes.
REQ-035 wbm_ack_i/wbm_err_i outside BUS SHALL be ignored.

Reset
REQ-036 rst_i=1 SHALL force IDLE immediately, independent of clk_i.
REQ-037 Reset SHALL set all outputs to 0 except req_ready_o, which SHALL be 1.
REQ-038 Reset SHALL clear ld_data_o, the timeout counter, the error flag and all registered request fields.
REQ-039 Reset during BUS SHALL drop cyc/stb immediately, with no done_o pulse after release.

Verification
REQ-040 Load word: addr_i=0x1006, we_i=0, ack with wbm_dat_i=0xDEADBEEF in the first BUS cycle -> wbm_adr_o=0x1004, sel=1111, done_o at N+2, ld_data_o=0xDEADBEEF, err_o=0.
REQ-041 Store byte: addr_i=0x2003, st_data_i=0x5A5A5A5A, st_sel_i=1000, ack delayed 3 cycles -> cyc/stb held 4 cycles, we=1, sel=1000, dat=0x5A5A5A5A, done_o one pulse.
REQ-042 Bus error: load with wbm_err_i=1 and wbm_ack_i=1 together -> done_o=err_o=1 in the same cycle, ld_data_o unchanged.
REQ-043 Timeout: TIMEOUT=4, slave never responds -> cyc drops after 4 BUS cycles, then done_o=err_o=1.
REQ-044 Back-to-back: req_valid_i held high for two requests -> second accepted only when req_ready_o=1 (M+2), with no overlapping cycles.
REQ-045 Reset mid-BUS: rst_i pulsed during BUS -> cyc/stb=0 asynchronously, no done_o after release, next request served normally.

Source files
------------

// File: rtl/dbus_wb_master_if.sv
// Request/response and Wishbone classic signals of the data-bus master.
// The master modport is the DUT view; slave is the LSU + Wishbone slave side.
interface dbus_wb_master_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] st_data_i;
    logic [3:0]  st_sel_i;
    logic [31:0] ld_data_o;
    logic        done_o;
    logic        err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        input  req_valid_i, we_i, addr_i, st_data_i, st_sel_i,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output req_ready_o, ld_data_o, done_o, err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
        output req_valid_i, we_i, addr_i, st_data_i, st_sel_i,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  req_ready_o, ld_data_o, done_o, err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );
endinterface

// File: rtl/dbus_wb_master.sv
// Single-outstanding LSU-to-Wishbone classic master with bus-error and
// timeout reporting; one request in flight, one done pulse per request.
module dbus_wb_master #(
    parameter int unsigned TIMEOUT = 1023
) (
    input logic             clk_i,
    input logic             rst_i,
    dbus_wb_master_if.master bus
);
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t         state_q, state_d;
    logic           we_q;
    logic [31:0]    addr_q;
    logic [31:0]    dat_q;
    logic [3:0]     sel_q;
    logic [31:0]    ld_q;
    logic           err_q;
    logic [CW-1:0]  cnt_q;
    logic           timeout;

    // Fires on the TIMEOUT-th consecutive BUS cycle without ack/err.
    assign timeout = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid_i) state_d = BUS;
            BUS:     if (bus.wbm_err_i || bus.wbm_ack_i || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load requests latch sel=1111/dat=0 here so the bus fields need no muxing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            dat_q  <= '0;
            sel_q  <= '0;
            ld_q   <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        we_q   <= bus.we_i;
                        addr_q <= bus.addr_i;
                        dat_q  <= bus.we_i ? bus.st_data_i : '0;
                        sel_q  <= bus.we_i ? bus.st_sel_i : '1;
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
                    end
                end
                BUS: begin
                    if (bus.wbm_err_i) begin
                        err_q <= 1'b1;
                    end else if (bus.wbm_ack_i) begin
                        if (!we_q) ld_q <= bus.wbm_dat_i;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP:    err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.wbm_cyc_o   = (state_q == BUS);
    assign bus.wbm_stb_o   = (state_q == BUS);
    assign bus.wbm_we_o    = we_q;
    assign bus.wbm_adr_o   = addr_q & 32'hFFFF_FFFC;
    assign bus.wbm_dat_o   = dat_q;
    assign bus.wbm_sel_o   = sel_q;
    assign bus.ld_data_o   = ld_q;
    assign bus.done_o      = (state_q == RESP);
    assign bus.err_o       = (state_q == RESP) && err_q;
endmodule

// File: tb/tb_dbus_wb_master.sv
// Self-checking bench for dbus_wb_master: directed vector table, hand-written
// corner sequences and random transactions against a behavioural model.
module tb_dbus_wb_master;
    localparam int unsigned TO = 4;
    localparam int R_ACK  = 0;
    localparam int R_ERR  = 1;
    localparam int R_BOTH = 2;
    localparam int R_NONE = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] model_ld;

    always #5 clk = ~clk;

    dbus_wb_master_if bus();

    dbus_wb_master #(.TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          delay;
        int          resp;
        logic [31:0] rdata;
        logic [31:0] e_adr;
        logic [3:0]  e_sel;
        logic [31:0] e_dat;
        int          e_cyc;
        logic        e_err;
        logic [31:0] e_ld;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] sel, input int delay, input int resp,
                                input logic [31:0] rdata, input logic [31:0] e_adr,
                                input logic [3:0] e_sel, input logic [31:0] e_dat,
                                input int e_cyc, input logic e_err, input logic [31:0] e_ld);
        vec_t v;
        v.we = we; v.addr = addr; v.data = data; v.sel = sel; v.delay = delay;
        v.resp = resp; v.rdata = rdata; v.e_adr = e_adr; v.e_sel = e_sel;
        v.e_dat = e_dat; v.e_cyc = e_cyc; v.e_err = e_err; v.e_ld = e_ld;
        return v;
    endfunction

    // Reference: the slave answers on cycle delay+1 unless TO cycles elapse first.
    function automatic vec_t model(input vec_t v, input logic [31:0] ld_prev);
        vec_t r = v;
        bool_answered: begin end
        r.e_adr = {v.addr[31:2], 2'b00};
        r.e_sel = v.we ? v.sel : 4'hF;
        r.e_dat = v.we ? v.data : 32'h0;
        r.e_ld  = ld_prev;
        if (v.resp == R_NONE || v.delay + 1 > int'(TO)) begin
            r.e_cyc = int'(TO);
            r.e_err = 1'b1;
        end else begin
            r.e_cyc = v.delay + 1;
            r.e_err = (v.resp != R_ACK);
            if (v.resp == R_ACK && !v.we) r.e_ld = v.rdata;
        end
        return r;
    endfunction

    task automatic scramble_req();
        bus.we_i      = 1'($urandom);
        bus.addr_i    = $urandom;
        bus.st_data_i = $urandom;
        bus.st_sel_i  = 4'($urandom);
    endtask

    // Starts and ends on a falling edge with the DUT idle.
    task automatic run_txn(input vec_t v, input bit scramble);
        int k;
        check("ready_before", 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i = 1'b1;
        bus.we_i        = v.we;
        bus.addr_i      = v.addr;
        bus.st_data_i   = v.data;
        bus.st_sel_i    = v.sel;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        if (scramble) scramble_req();
        k = 0;
        while (bus.wbm_cyc_o === 1'b1 && k < 40) begin
            k++;
            check("stb", 32'(bus.wbm_stb_o), 32'd1);
            check("adr", bus.wbm_adr_o, v.e_adr);
            check("sel", 32'(bus.wbm_sel_o), 32'(v.e_sel));
            check("dat", bus.wbm_dat_o, v.e_dat);
            check("we", 32'(bus.wbm_we_o), 32'(v.we));
            check("busy_ready", 32'({bus.req_ready_o, bus.done_o}), 32'd0);
            if (v.resp != R_NONE && k == v.delay + 1) begin
                bus.wbm_ack_i = (v.resp != R_ERR);
                bus.wbm_err_i = (v.resp != R_ACK);
                bus.wbm_dat_i = v.rdata;
            end
            @(negedge clk);
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            bus.wbm_dat_i = $urandom;
            if (scramble) scramble_req();
        end
        check("bus_cycles", 32'(k), 32'(v.e_cyc));
        check("done", 32'(bus.done_o), 32'd1);
        check("err", 32'(bus.err_o), 32'(v.e_err));
        check("resp_ready", 32'(bus.req_ready_o), 32'd0);
        check("resp_stb", 32'(bus.wbm_stb_o), 32'd0);
        @(negedge clk);
        check("done_clear", 32'({bus.done_o, bus.err_o}), 32'd0);
        check("ready_after", 32'(bus.req_ready_o), 32'd1);
        check("ld_data", bus.ld_data_o, v.e_ld);
    endtask

    initial begin
        vec_t v;
        int   pulses;

        rst = 1'b1;
        bus.req_valid_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0;
        bus.st_data_i = '0; bus.st_sel_i = '0;
        bus.wbm_dat_i = '0; bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0;
        #12;
        check("rst_ready", 32'(bus.req_ready_o), 32'd1);
        check("rst_ctl", 32'({bus.done_o, bus.err_o, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}), 32'd0);
        check("rst_adr", bus.wbm_adr_o, 32'h0);
        check("rst_dat", bus.wbm_dat_o, 32'h0);
        check("rst_sel", 32'(bus.wbm_sel_o), 32'h0);
        check("rst_ld", bus.ld_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        tbl[0] = mk(1'b0, 32'h0000_1006, 32'h0, 4'h0, 0, R_ACK, 32'hDEAD_BEEF,
                    32'h0000_1004, 4'hF, 32'h0, 1, 1'b0, 32'hDEAD_BEEF);
        tbl[1] = mk(1'b1, 32'h0000_2003, 32'h5A5A_5A5A, 4'b1000, 3, R_ACK, 32'h1111_1111,
                    32'h0000_2000, 4'b1000, 32'h5A5A_5A5A, 4, 1'b0, 32'hDEAD_BEEF);
        tbl[2] = mk(1'b0, 32'h0000_3000, 32'h0, 4'h0, 1, R_BOTH, 32'h1234_5678,
                    32'h0000_3000, 4'hF, 32'h0, 2, 1'b1, 32'hDEAD_BEEF);
        tbl[3] = mk(1'b0, 32'h0000_4001, 32'hFFFF_FFFF, 4'h5, 0, R_NONE, 32'h0,
                    32'h0000_4000, 4'hF, 32'h0, 4, 1'b1, 32'hDEAD_BEEF);
        tbl[4] = mk(1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0, 2, R_ACK, 32'h0BAD_F00D,
                    32'hFFFF_FFFC, 4'hF, 32'h0, 3, 1'b0, 32'h0BAD_F00D);
        tbl[5] = mk(1'b1, 32'h0000_5002, 32'hA5A5_A5A5, 4'b0011, 0, R_ERR, 32'h9999_9999,
                    32'h0000_5000, 4'b0011, 32'hA5A5_A5A5, 1, 1'b1, 32'h0BAD_F00D);
        tbl[6] = mk(1'b0, 32'h0000_6004, 32'h0, 4'h0, 3, R_ACK, 32'hCAFE_F00D,
                    32'h0000_6004, 4'hF, 32'h0, 4, 1'b0, 32'hCAFE_F00D);
        tbl[7] = mk(1'b1, 32'h0000_7000, 32'h0102_0304, 4'hF, 5, R_ACK, 32'h0,
                    32'h0000_7000, 4'hF, 32'h0102_0304, 4, 1'b1, 32'hCAFE_F00D);

        for (int i = 0; i < 8; i++) run_txn(tbl[i], 1'b0);
        model_ld = 32'hCAFE_F00D;

        // Back-to-back: req_valid held high across two requests.
        bus.req_valid_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h0000_8000;
        @(negedge clk);
        check("b2b_a_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        check("b2b_a_adr", bus.wbm_adr_o, 32'h0000_8000);
        bus.we_i = 1'b1; bus.addr_i = 32'h0000_9008; bus.st_data_i = 32'h77; bus.st_sel_i = 4'hF;
        bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'h1357_2468;
        @(negedge clk);
        bus.wbm_ack_i = 1'b0;
        check("b2b_resp", 32'({bus.done_o, bus.wbm_cyc_o, bus.req_ready_o}), 32'b100);
        check("b2b_ld", bus.ld_data_o, 32'h1357_2468);
        @(negedge clk);
        check("b2b_idle", 32'({bus.done_o, bus.wbm_cyc_o, bus.req_ready_o}), 32'b001);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("b2b_b_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        check("b2b_b_adr", bus.wbm_adr_o, 32'h0000_9008);
        check("b2b_b_fields", {bus.wbm_dat_o[27:0], bus.wbm_sel_o}, {28'h77, 4'hF});
        check("b2b_b_we", 32'(bus.wbm_we_o), 32'd1);
        bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'hFFFF_0000;
        @(negedge clk);
        bus.wbm_ack_i = 1'b0;
        check("b2b_b_done", 32'({bus.done_o, bus.err_o}), 32'b10);
        @(negedge clk);
        check("b2b_b_ld", bus.ld_data_o, 32'h1357_2468);
        model_ld = 32'h1357_2468;

        // Asynchronous reset in the middle of a bus cycle.
        bus.req_valid_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h0000_A000;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        check("mid_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_cyc", 32'({bus.wbm_cyc_o, bus.wbm_stb_o}), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready_o), 32'd1);
        check("mid_rst_adr", bus.wbm_adr_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_ld = 32'h0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pulses += int'(bus.done_o);
        end
        check("mid_rst_no_done", 32'(pulses), 32'd0);
        check("mid_rst_ld", bus.ld_data_o, 32'h0);
        v = mk(1'b0, 32'h0000_B00C, 32'h0, 4'h0, 1, R_ACK, 32'h600D_CAFE,
               0, 0, 0, 0, 1'b0, 0);
        v = model(v, model_ld);
        run_txn(v, 1'b0);
        model_ld = v.e_ld;

        // Random traffic, with stray ack/err pulses while idle.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.wbm_ack_i = 1'b1;
                bus.wbm_err_i = 1'($urandom);
                bus.wbm_dat_i = $urandom;
                @(negedge clk);
                bus.wbm_ack_i = 1'b0;
                bus.wbm_err_i = 1'b0;
                check("idle_ack_ignored", 32'({bus.done_o, bus.wbm_cyc_o, bus.req_ready_o}), 32'b001);
                check("idle_ack_ld", bus.ld_data_o, model_ld);
            end
            v.we    = 1'($urandom);
            v.addr  = $urandom;
            v.data  = $urandom;
            v.sel   = 4'($urandom);
            v.delay = $urandom_range(0, 5);
            case ($urandom_range(0, 9))
                7:       v.resp = R_ERR;
                8:       v.resp = R_BOTH;
                9:       v.resp = R_NONE;
                default: v.resp = R_ACK;
            endcase
            v.rdata = $urandom;
            v = model(v, model_ld);
            run_txn(v, 1'b1);
            model_ld = v.e_ld;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
